// File: rtl/smm_sdiv_seq_32s_32s_32.sv
// Sequential signed divider: restoring radix-2 on magnitudes, one quotient bit per enabled cycle.
// Optional remainder output is compiled in when SMM_SDIV_REM_EN is defined.
module smm_sdiv_seq_32s_32s_32 #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 32,
    parameter int dout_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  div0
`ifdef SMM_SDIV_REM_EN
    ,
    output logic [din0_WIDTH-1:0] rem
`endif
);

    localparam int W  = din0_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [W-1:0]    quo_reg;
    logic [W-1:0]    rmd_reg;
    logic [W-1:0]    dvs_reg;
    logic            a_neg_reg, q_neg_reg, zero_reg;
    logic [dout_WIDTH-1:0] dout_reg;
    logic            div0_reg;

    logic [W-1:0]    dvs_ext;
    logic [W:0]      shifted, trial;
    logic [W-1:0]    q_step, rmd_step, q_signed;
    logic            accept;

    // ID is informational only; it joins the configuration sanity check so it is referenced.
    generate
        if (din1_WIDTH > din0_WIDTH || dout_WIDTH != din0_WIDTH || ID < 0) begin : g_bad_cfg
            $error("smm_sdiv_seq_32s_32s_32: unsupported width/ID configuration");
        end
        if (din1_WIDTH == W) begin : g_dvs_same
            assign dvs_ext = din1;
        end else begin : g_dvs_sext
            assign dvs_ext = {{(W-din1_WIDTH){din1[din1_WIDTH-1]}}, din1};
        end
    endgenerate

    assign accept = ce && (state_reg == IDLE) && start;

    always_comb begin
        state_next = state_reg;
        if (ce) begin
            case (state_reg)
                IDLE:    if (start) state_next = CALC;
                CALC:    if (cnt_reg == '0) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // One restoring step: shift next dividend bit into the partial remainder, keep the trial if non-negative.
    always_comb begin
        shifted = {rmd_reg, quo_reg[W-1]};
        trial   = shifted - {1'b0, dvs_reg};
        if (trial[W]) begin
            rmd_step = shifted[W-1:0];
            q_step   = {quo_reg[W-2:0], 1'b0};
        end else begin
            rmd_step = trial[W-1:0];
            q_step   = {quo_reg[W-2:0], 1'b1};
        end
        q_signed = q_neg_reg ? -q_step : q_step;
    end

`ifdef SMM_SDIV_REM_EN
    logic [W-1:0] rem_reg;
    logic [W-1:0] r_signed;

    // With a zero divisor the remainder register ends up holding |dividend|, so no special case is needed.
    assign r_signed = a_neg_reg ? -rmd_step : rmd_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_reg <= '0;
        end else if (ce && state_reg == CALC && cnt_reg == '0) begin
            rem_reg <= r_signed;
        end
    end

    assign rem = rem_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            quo_reg   <= '0;
            rmd_reg   <= '0;
            dvs_reg   <= '0;
            a_neg_reg <= 1'b0;
            q_neg_reg <= 1'b0;
            zero_reg  <= 1'b0;
            dout_reg  <= '0;
            div0_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cnt_reg   <= CW'(W-1);
                quo_reg   <= din0[W-1] ? -din0 : din0;
                rmd_reg   <= '0;
                dvs_reg   <= dvs_ext[W-1] ? -dvs_ext : dvs_ext;
                a_neg_reg <= din0[W-1];
                q_neg_reg <= din0[W-1] ^ dvs_ext[W-1];
                zero_reg  <= (dvs_ext == '0);
            end else if (ce && state_reg == CALC) begin
                quo_reg <= q_step;
                rmd_reg <= rmd_step;
                cnt_reg <= cnt_reg - 1'b1;
                if (cnt_reg == '0) begin
                    dout_reg <= zero_reg ? '1 : q_signed;
                    div0_reg <= zero_reg;
                end
            end
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign dout = dout_reg;
    assign div0 = div0_reg;

endmodule
